fetch_stall_responder: RTL
==========================

Name: fetch_stall_responder

Overview:
- Responder side of the pipeline stall protocol; the hazard/stall unit is the requester.
- Owns the PC register and the IF/ID pipeline register.
- Accepts stall requests with a length and freezes PC and IF/ID for exactly that many clock edges.
- Accepts branch/jump flushes that redirect the PC and insert a bubble.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 4, width of stall_len and the internal hold counter.
- NOP_INSTR, 32'h0000_0000, instruction written into IF/ID on flush or reset (sll $0,$0,0).

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_req  in  1  stall request from the hazard unit; sampled each rising edge.
- stall_len  in  CNT_W  number of edges to hold; 0 is treated as 1; valid only with stall_req.
- flush  in  1  branch/jump taken; redirect the PC and bubble IF/ID.
- branch_target  in  32  new PC when flush=1.
- instr_in  in  32  instruction memory output for the current pc.
- pc  out  32  current fetch address.
- ifid_instr  out  32  IF/ID latched instruction.
- ifid_pc4  out  32  IF/ID latched pc+4.
- ifid_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- stall_ack  out  1  one-cycle registered pulse: a new stall request was accepted.
- stall_active  out  1  combinational: PC/IF-ID will hold at the next edge.

Behaviour:
- Reset (async, immediate) values:
  - pc = RESET_PC, ifid_instr = NOP_INSTR, ifid_pc4 = 0, ifid_valid = 0, stall_ack = 0.
  - Hold counter = 0, state = RUN.
- Reset asserted mid-stall abandons the stall completely; after release the block fetches from RESET_PC.
- States are RUN and HOLD. Effective length is L = (stall_len == 0) ? 1 : stall_len.
- Priority at each edge is flush > stall > normal advance.
- Flush (any state):
  - pc <= branch_target; ifid_instr <= NOP_INSTR; ifid_valid <= 0; ifid_pc4 <= 0.
  - Counter <= 0, state <= RUN, stall_ack <= 0.
  - A simultaneous stall_req is dropped.
- RUN, no stall_req: pc <= pc+4 (mod 2^32, wrap from 32'hFFFF_FFFC to 0); ifid_instr <= instr_in; ifid_pc4 <= pc+4; ifid_valid <= 1.
- RUN, stall_req=1:
  - pc and the IF/ID registers hold this edge; stall_ack <= 1.
  - If L > 1: counter <= L-1, state <= HOLD. Otherwise stay in RUN.
- HOLD, no new request: hold all registers; counter <= counter-1; when counter == 1, state <= RUN. stall_ack <= 0.
- HOLD, stall_req=1 (extension):
  - Hold this edge; stall_ack <= 1.
  - New counter = max(counter-1, L-1).
  - If the new counter is 0, state <= RUN; otherwise stay in HOLD.
- Net effect: a request of length L accepted in RUN freezes exactly L consecutive edges; the next edge advances.
- stall_active = (state == HOLD) | stall_req, with no gating by flush. Downstream units must gate it with flush themselves.
- Latency: instr_in is captured in IF/ID at the same edge the PC advances. There is no extra pipeline delay.

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- Defined:
  - Adds output port stall_cycles (32 bits), reset to 0.
  - Increments on every edge where a hold occurred; flush edges do not count.
  - Saturates at 32'hFFFF_FFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, no requests, instr_in = 32'h2008_0005:
  - pc reads 0, 4, 8 on successive edges; ifid_pc4 = 4 after edge 1; ifid_valid = 1.
- stall_req=1 with stall_len=1 at pc=8:
  - pc stays 8 for one edge, then 12; stall_ack high exactly one cycle; stall_cycles = 1 if enabled.
- stall_req with stall_len=3 at pc=16:
  - pc = 16 across 3 edges, then 20; a stall_len=0 request behaves like stall_len=1.
- stall_len=4 accepted, then stall_len=5 issued 1 edge later:
  - Total frozen edges = 6; max rule applies; stall_ack pulses twice.
- flush=1, branch_target=32'h40, same cycle as stall_req:
  - Next edge: pc = 32'h40, ifid_instr = NOP_INSTR, ifid_valid = 0, no stall_ack, state RUN.
- rst asserted during a 5-edge HOLD; then pc forced near wrap:
  - On reset: outputs return to reset values immediately.
  - From pc = 32'hFFFF_FFFC, the next pc = 0.

Source files
------------

// File: rtl/fetch_stall_responder.sv
// Fetch-stage stall responder: owns the PC and IF/ID register, honours stall/flush requests.
// Optional stall cycle counter output enabled by defining STALL_PERF_CNT_EN.
module fetch_stall_responder #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CNT_W     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_req,
    input  logic [CNT_W-1:0] stall_len,
    input  logic             flush,
    input  logic [31:0]      branch_target,
    input  logic [31:0]      instr_in,
    output logic [31:0]      pc,
    output logic [31:0]      ifid_instr,
    output logic [31:0]      ifid_pc4,
    output logic             ifid_valid,
    output logic             stall_ack,
`ifdef STALL_PERF_CNT_EN
    output logic [31:0]      stall_cycles,
`endif
    output logic             stall_active
);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] eff_len_m1;
    logic [CNT_W-1:0] cnt_m1;
    logic [CNT_W-1:0] ext_cnt;
    logic [31:0]      pc_plus4;

    // A zero-length request still freezes one edge, so L-1 is 0 for both 0 and 1.
    always_comb begin
        eff_len_m1 = (stall_len == '0) ? '0 : stall_len - 1'b1;
        cnt_m1     = (hold_cnt == '0) ? '0 : hold_cnt - 1'b1;
        ext_cnt    = (cnt_m1 > eff_len_m1) ? cnt_m1 : eff_len_m1;
        pc_plus4   = pc + 32'd4;
    end

    assign stall_active = (state == HOLD) | stall_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            ifid_instr <= NOP_INSTR;
            ifid_pc4   <= '0;
            ifid_valid <= 1'b0;
            stall_ack  <= 1'b0;
            hold_cnt   <= '0;
            state      <= RUN;
        end else if (flush) begin
            pc         <= branch_target;
            ifid_instr <= NOP_INSTR;
            ifid_pc4   <= '0;
            ifid_valid <= 1'b0;
            stall_ack  <= 1'b0;
            hold_cnt   <= '0;
            state      <= RUN;
        end else begin
            case (state)
                RUN: begin
                    if (stall_req) begin
                        stall_ack <= 1'b1;
                        if (eff_len_m1 != '0) begin
                            hold_cnt <= eff_len_m1;
                            state    <= HOLD;
                        end
                    end else begin
                        pc         <= pc_plus4;
                        ifid_instr <= instr_in;
                        ifid_pc4   <= pc_plus4;
                        ifid_valid <= 1'b1;
                        stall_ack  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (stall_req) begin
                        // Extension keeps whichever remaining hold is longer.
                        stall_ack <= 1'b1;
                        hold_cnt  <= ext_cnt;
                        if (ext_cnt == '0) begin
                            state <= RUN;
                        end
                    end else begin
                        stall_ack <= 1'b0;
                        hold_cnt  <= cnt_m1;
                        if (hold_cnt <= 1) begin
                            state <= RUN;
                        end
                    end
                end
                default: begin
                    state    <= RUN;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

`ifdef STALL_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall_active && !flush && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule
